nibble_sweep_gen: RTL and testbench
===================================

# nibble_sweep_gen

Stimulus sequencer that drives the 4-input XOR parity tree. Generates four divided phases clk1..clk4 (clk1 fastest, each next at half the rate) by stepping a 4-bit code at a programmable rate, for one full 16-state sweep or continuously. Also provides the expected parity of the code it drives, so the downstream checker can compare it against the tree output.

## Interface
- DIV_W, 16, width of the half-period divisor input.
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a sweep from IDLE.
- stop  in  1  pulse; aborts a sweep in progress.
- half_period  in  DIV_W  clk cycles each code value is held; sampled on accepted start; 0 is treated as 1.
- loop  in  1  sampled on accepted start; 1 = continuous sweeping, 0 = one sweep.
- gray_mode  in  1  sampled on accepted start; 1 = drive Gray-coded phases.
- clk1, clk2, clk3, clk4  out  1 each  phase outputs = drive-code bits 0..3.
- exp_parity  out  1  XOR of clk1..clk4 (registered, aligned with them).
- busy  out  1  high in RUN.
- step  out  1  one-cycle pulse on every code advance.
- wrap  out  1  one-cycle pulse when the code advances from 15 to 0.
- done  out  1  one-cycle pulse on completion of a one-shot sweep.

## Operation
- States: IDLE, RUN.
- IDLE: code = 0; outputs 0000; exp_parity 0. When start = 1, capture half_period (0 -> 1), loop and gray_mode; load the divider with H-1; go to RUN.
- RUN: the divider decrements each cycle. At 0 it reloads H-1, code increments mod 16 and step pulses.
- Binary mode: {clk4,clk3,clk2,clk1} = code. Gray mode: = code ^ (code >> 1). In Gray mode exactly one phase toggles per step, so exp_parity alternates every step.
- At the 15 -> 0 advance, wrap pulses. If loop = 0, done also pulses and the FSM returns to IDLE on the same edge. If loop = 1, the FSM stays in RUN.
- stop in RUN: go to IDLE on the next edge, code cleared to 0, no done.
- start while in RUN is ignored. Input changes in RUN have no effect until the next accepted start.
- start and stop in the same IDLE cycle: stop wins and start is dropped.
- Reset (asynchronous, any time): IDLE, code 0, divider 0. All outputs 0: clk1..4, exp_parity, busy, step, wrap, done.

## Timing
- start sampled at edge N: busy = 1 and code 0 visible after edge N; first step at edge N+H.
- Each code value is held exactly H cycles. A one-shot sweep occupies 16*H cycles in RUN.
- done and wrap rise after edge N+16*H. At that same edge busy falls and the outputs read 0000.
- All outputs are registered; there is no combinational path from inputs to outputs.
- stop sampled at edge M: busy = 0 and outputs 0000 after edge M.

## Configuration
- NIBBLE_SWEEP_GRAY_EN defined: Gray mode is available as described.
- Undefined: gray_mode is ignored, binary order is always used, and the Gray conversion logic is absent. The port remains present.

## Structure
- Package nibble_sweep_pkg contains:
  - state enum (IDLE, RUN)
  - CODE_W = 4
  - LAST_CODE = 4'hF
  - function bin2gray.
- Sub-module sweep_tick_div: loadable DIV_W down-counter.
  - Inputs: load, load value, enable.
  - Output: tick pulse at terminal count.
  - It holds the RUN-state divider.

## Test plan
- H=2, binary, one-shot. Start at cycle 0 -> code 0,1,2..15 each held 2 cycles. exp_parity sequence 0,1,1,0,1,0,0,1,... done and wrap after 32 RUN cycles, then busy = 0.
- H=1, Gray, loop (NIBBLE_SWEEP_GRAY_EN defined) -> exactly one phase toggles per cycle, exp_parity alternates every cycle. wrap pulses every 16 cycles, done never asserts.
- half_period = 0 -> behaves identically to H = 1: step every cycle.
- H=3, binary. Stop at RUN cycle 20 (code 6) -> next cycle outputs 0000, busy 0, no done.
- Assert rst_n low mid-sweep at code 9 -> all outputs 0 immediately, no clock required. After release, stays IDLE until start.
- start with stop in the same cycle -> stays IDLE. start during RUN at code 4 -> sweep continues unchanged, with no restart.

Source files
------------

// File: rtl/nibble_sweep_pkg.sv
// Shared types, constants and helpers for the nibble sweep stimulus generator.
// The Gray drive option is compiled in only when NIBBLE_SWEEP_GRAY_EN is defined.
package nibble_sweep_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_e;

    localparam int          CODE_W    = 4;
    localparam logic [3:0]  LAST_CODE = 4'hF;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return bin ^ {1'b0, bin[CODE_W-1:1]};
    endfunction

    function automatic logic parity4(input logic [CODE_W-1:0] vec);
        return vec[0] ^ vec[1] ^ vec[2] ^ vec[3];
    endfunction

endpackage

// File: rtl/nibble_sweep_gen_tick_div.sv
// Loadable down-counter that paces code advances; ticks when enabled at terminal count.
module sweep_tick_div
    import nibble_sweep_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tick_o
);

    localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = en_i & (cnt_q == CNT_ZERO);

    // Load has priority so the owner can reload on the same cycle it sees the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nibble_sweep_gen.sv
// Phase sequencer for the 4-input parity tree: steps a 4-bit code at a programmable rate.
// Gray-coded drive is available only when NIBBLE_SWEEP_GRAY_EN is defined.
module nibble_sweep_gen
    import nibble_sweep_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] half_period,
    input  logic             loop,
    input  logic             gray_mode,
    output logic             clk1,
    output logic             clk2,
    output logic             clk3,
    output logic             clk4,
    output logic             exp_parity,
    output logic             busy,
    output logic             step,
    output logic             wrap,
    output logic             done
);

    localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CODE_W-1:0] CODE_ZERO = 4'h0;
    localparam logic [CODE_W-1:0] CODE_ONE  = 4'h1;

    sweep_state_e      state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [DIV_W-1:0]  reload_q, reload_d;
    logic              loop_q, loop_d;
    logic [CODE_W-1:0] phase_q, phase_d;
    logic              par_q, par_d;
    logic              busy_q, busy_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;

    logic              div_load_s;
    logic [DIV_W-1:0]  div_val_s;
    logic              div_en_s;
    logic              tick_s;
    logic [CODE_W-1:0] drive_s;

    sweep_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (div_load_s),
        .load_val_i (div_val_s),
        .en_i       (div_en_s),
        .tick_o     (tick_s)
    );

`ifdef NIBBLE_SWEEP_GRAY_EN
    logic gray_q, gray_d;
`else
    logic unused_gray_s;
    assign unused_gray_s = gray_mode;
`endif

    // Sweep control: start/stop handling, code advance and end-of-sweep pulses.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        reload_d   = reload_q;
        loop_d     = loop_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        done_d     = 1'b0;
        div_load_s = 1'b0;
        div_val_s  = DIV_ZERO;
        div_en_s   = 1'b0;
`ifdef NIBBLE_SWEEP_GRAY_EN
        gray_d     = gray_q;
`endif
        case (state_q)
            ST_IDLE: begin
                code_d = CODE_ZERO;
                // stop in the same cycle as start cancels the start
                if (start && !stop) begin
                    state_d    = ST_RUN;
                    reload_d   = (half_period == DIV_ZERO) ? DIV_ZERO : (half_period - DIV_ONE);
                    loop_d     = loop;
                    div_load_s = 1'b1;
                    div_val_s  = (half_period == DIV_ZERO) ? DIV_ZERO : (half_period - DIV_ONE);
`ifdef NIBBLE_SWEEP_GRAY_EN
                    gray_d     = gray_mode;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                div_en_s = 1'b1;
                if (stop) begin
                    state_d    = ST_IDLE;
                    code_d     = CODE_ZERO;
                    div_load_s = 1'b1;
                    div_val_s  = DIV_ZERO;
                end else if (tick_s) begin
                    div_load_s = 1'b1;
                    div_val_s  = reload_q;
                    step_d     = 1'b1;
                    code_d     = code_q + CODE_ONE;
                    if (code_q == LAST_CODE) begin
                        wrap_d = 1'b1;
                        if (!loop_q) begin
                            done_d     = 1'b1;
                            state_d    = ST_IDLE;
                            code_d     = CODE_ZERO;
                            div_val_s  = DIV_ZERO;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        wrap_d = 1'b0;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = CODE_ZERO;
            end
        endcase
    end

    // Output drive: phases and expected parity follow the next code so they stay aligned.
    always_comb begin
`ifdef NIBBLE_SWEEP_GRAY_EN
        drive_s = gray_d ? bin2gray(code_d) : code_d;
`else
        drive_s = code_d;
`endif
        phase_d = drive_s;
        par_d   = parity4(drive_s);
        busy_d  = (state_d == ST_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            code_q   <= CODE_ZERO;
            reload_q <= DIV_ZERO;
            loop_q   <= 1'b0;
            phase_q  <= CODE_ZERO;
            par_q    <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            reload_q <= reload_d;
            loop_q   <= loop_d;
            phase_q  <= phase_d;
            par_q    <= par_d;
            busy_q   <= busy_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
        end
    end

`ifdef NIBBLE_SWEEP_GRAY_EN
    // Drive-order selection captured at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q <= 1'b0;
        end else begin
            gray_q <= gray_d;
        end
    end
`endif

    assign clk1       = phase_q[0];
    assign clk2       = phase_q[1];
    assign clk3       = phase_q[2];
    assign clk4       = phase_q[3];
    assign exp_parity = par_q;
    assign busy       = busy_q;
    assign step       = step_q;
    assign wrap       = wrap_q;
    assign done       = done_q;

endmodule

// File: tb/tb_nibble_sweep_gen.sv
// Scoreboard bench for nibble_sweep_gen: expected output vectors are queued per edge and checked after it.
module tb_nibble_sweep_gen;

`ifdef NIBBLE_SWEEP_GRAY_EN
    localparam bit GRAY_EN = 1'b1;
`else
    localparam bit GRAY_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] half_period;
    logic        loop;
    logic        gray_mode;
    logic        clk1, clk2, clk3, clk4;
    logic        exp_parity, busy, step, wrap, done;

    logic [8:0]  sb_q[$];
    int          tests;
    int          fails;

    nibble_sweep_gen #(.DIV_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
        .loop        (loop),
        .gray_mode   (gray_mode),
        .clk1        (clk1),
        .clk2        (clk2),
        .clk3        (clk3),
        .clk4        (clk4),
        .exp_parity  (exp_parity),
        .busy        (busy),
        .step        (step),
        .wrap        (wrap),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {busy, step, wrap, done, exp_parity, clk4, clk3, clk2, clk1}
    function automatic logic [8:0] obs_vec();
        return {busy, step, wrap, done, exp_parity, clk4, clk3, clk2, clk1};
    endfunction

    function automatic logic [8:0] model_vec(input logic b, input logic s, input logic w,
                                             input logic d, input int code, input logic gr);
        logic [3:0] c;
        logic [3:0] drv;
        c   = code[3:0];
        drv = gr ? (c ^ {1'b0, c[3:1]}) : c;
        return {b, s, w, d, ^drv, drv};
    endfunction

    // Expected outputs after edge k of a sweep started at edge 0.
    function automatic logic [8:0] sweep_expect(input int k, input int h, input bit lp,
                                                input bit gr, input int stop_k);
        int  ticks;
        bit  stp;
        if (stop_k > 0 && k >= stop_k) return 9'd0;
        if (!lp && k > 16 * h)         return 9'd0;
        if (!lp && k == 16 * h)        return model_vec(1'b0, 1'b1, 1'b1, 1'b1, 0, gr);
        ticks = k / h;
        stp   = (k > 0) && (k % h == 0);
        return model_vec(1'b1, stp, stp && (ticks % 16 == 0), 1'b0, ticks % 16, gr);
    endfunction

    task automatic run_sweep(input string name, input int h_in, input bit lp, input bit gr,
                             input int ncyc, input int stop_k, input int restart_k);
        int         h;
        bit         gre;
        logic [8:0] e;
        logic [8:0] o;
        h           = (h_in == 0) ? 1 : h_in;
        gre         = gr & GRAY_EN;
        half_period = h_in[15:0];
        loop        = lp;
        gray_mode   = gr;
        start       = 1'b1;
        stop        = 1'b0;
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) begin
                start       = (k == restart_k);
                stop        = (k == stop_k);
                half_period = 16'd5;
                loop        = ~lp;
                gray_mode   = ~gr;
            end
            sb_q.push_back(sweep_expect(k, h, lp, gre, stop_k));
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            o = obs_vec();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s edge=%0d got=%b expected=%b", name, k, o, e);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] o;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        half_period = 16'd0;
        loop = 1'b0;
        gray_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(9'd0);
        o = obs_vec();
        tests++;
        if (o !== sb_q.pop_front()) begin
            fails++;
            $display("FAIL reset_state got=%b expected=%b", o, 9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(9'd0);
            @(posedge clk);
            #1;
            o = obs_vec();
            tests++;
            if (o !== sb_q.pop_front()) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got=%b expected=%b", i, o, 9'd0);
            end
        end
    endtask

    task automatic test_oneshot_binary();
        run_sweep("oneshot_h2", 2, 1'b0, 1'b0, 36, -1, -1);
    endtask

    task automatic test_gray_loop();
        run_sweep("gray_loop_h1", 1, 1'b1, 1'b1, 42, 40, -1);
    endtask

    task automatic test_zero_half();
        run_sweep("half_zero", 0, 1'b0, 1'b0, 19, -1, -1);
    endtask

    task automatic test_stop();
        run_sweep("stop_h3", 3, 1'b0, 1'b0, 25, 21, -1);
    endtask

    task automatic test_start_in_run();
        run_sweep("start_in_run_h2", 2, 1'b0, 1'b0, 34, -1, 9);
    endtask

    task automatic test_start_stop_same();
        logic [8:0] o;
        half_period = 16'd1;
        loop  = 1'b1;
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(9'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            o = obs_vec();
            tests++;
            if (o !== sb_q.pop_front()) begin
                fails++;
                $display("FAIL start_stop_same cyc=%0d got=%b expected=%b", i, o, 9'd0);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] o;
        run_sweep("pre_reset_h2", 2, 1'b0, 1'b0, 18, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(9'd0);
        o = obs_vec();
        tests++;
        if (o !== sb_q.pop_front()) begin
            fails++;
            $display("FAIL async_reset got=%b expected=%b", o, 9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(9'd0);
            @(posedge clk);
            #1;
            o = obs_vec();
            tests++;
            if (o !== sb_q.pop_front()) begin
                fails++;
                $display("FAIL post_reset_idle cyc=%0d got=%b expected=%b", i, o, 9'd0);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_oneshot_binary();
        test_gray_loop();
        test_zero_half();
        test_stop();
        test_start_in_run();
        test_start_stop_same();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
